div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage; the producer on the HILO register-file write port. It accepts a DIV/DIVU request with a start/busy handshake and runs a restoring radix-2 iteration. It then presents the remainder on the hi write data and the quotient on the lo write data, with a one-cycle write strobe. The pipeline stalls on `busy`; exception flush aborts the operation via `cancel`.

---
 rtl/div_pkg.sv | 38 +++
 rtl/div_step.sv | 47 ++++
 rtl/div_unit.sv | 165 ++++++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants, FSM state encoding and helpers for the
//                multi-cycle HILO divider (div_unit / div_step).
//  Contents    : DATA_BUS   - datapath width (32)
//                DIV_CYCLES - iterations per divide (one quotient bit each)
//                STATE_W    - FSM state register width
//                div_state_t- IDLE / PREP / CALC / DONE
//                neg32      - two's complement negate, 32-bit wrap
//                abs32      - absolute value, 32-bit wrap
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DATA_BUS   = 32;
  localparam int DIV_CYCLES = 32;
  localparam int STATE_W    = 2;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Negation wraps, so neg32(0x80000000) == 0x80000000.
  function automatic logic [DATA_BUS-1:0] neg32(input logic [DATA_BUS-1:0] v);
    return (~v) + {{(DATA_BUS-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_BUS-1:0] abs32(input logic [DATA_BUS-1:0] v);
    return v[DATA_BUS-1] ? neg32(v) : v;
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One iteration of a restoring radix-2 divider. Purely
//                combinational. The quotient register doubles as the
//                dividend shift register: its MSB feeds the remainder while
//                the new quotient bit enters at the LSB.
//  Ports       : rem      in  33 - current partial remainder
//                quo      in  32 - current quotient / remaining dividend bits
//                divisor  in  32 - (absolute) divisor
//                rem_next out 33 - partial remainder after this step
//                quo_next out 32 - quotient after this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import div_pkg::*;
(
  input  logic [DATA_BUS:0]   rem,
  input  logic [DATA_BUS-1:0] quo,
  input  logic [DATA_BUS-1:0] divisor,
  output logic [DATA_BUS:0]   rem_next,
  output logic [DATA_BUS-1:0] quo_next
);

  logic [DATA_BUS:0] w_shift;
  logic [DATA_BUS:0] w_trial;
  // A committed remainder is always below the divisor, so its top bit is
  // zero by construction and drops out of the shift.
  logic              w_unused_rem_msb;

  assign w_unused_rem_msb = rem[DATA_BUS];

  assign w_shift = {rem[DATA_BUS-1:0], quo[DATA_BUS-1]};
  assign w_trial = w_shift - {1'b0, divisor};

  always_comb begin
    rem_next = w_shift;
    quo_next = {quo[DATA_BUS-2:0], 1'b0};
    // Non-negative trial result: the divisor fits, keep the difference.
    if (!w_trial[DATA_BUS]) begin
      rem_next = w_trial;
      quo_next = {quo[DATA_BUS-2:0], 1'b1};
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle 32-bit DIV/DIVU unit feeding the HILO write
//                port. Start/busy handshake, sign-magnitude conversion,
//                32 restoring iterations, then a one-cycle write strobe with
//                remainder on hi_out and quotient on lo_out.
//                Latency: start sampled at edge k -> done in cycle k+34.
//  Ports       : clk       in  1  - clock, rising edge
//                rst       in  1  - synchronous active-high reset
//                start     in  1  - request, sampled only in IDLE
//                is_signed in  1  - 1 = DIV, 0 = DIVU
//                dividend  in  32 - numerator
//                divisor   in  32 - denominator
//                cancel    in  1  - flush, aborts any operation
//                busy      out 1  - operation in flight (PREP/CALC/DONE)
//                done      out 1  - HILO write enable, one-cycle pulse
//                hi_out    out 32 - remainder
//                lo_out    out 32 - quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_BUS-1:0] dividend,
  input  logic [DATA_BUS-1:0] divisor,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic [DATA_BUS-1:0] hi_out,
  output logic [DATA_BUS-1:0] lo_out
);

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_t          r_state;
  div_state_t          w_state_nx;

  logic [DATA_BUS:0]   r_rem;
  logic [DATA_BUS-1:0] r_quo;
  logic [DATA_BUS-1:0] r_dsr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sgn;
  logic                r_q_neg;
  logic                r_r_neg;
  logic [DATA_BUS-1:0] r_hi;
  logic [DATA_BUS-1:0] r_lo;

  logic [DATA_BUS:0]   w_rem_nx;
  logic [DATA_BUS-1:0] w_quo_nx;
  logic                w_last;

  div_step u_div_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_dsr),
    .rem_next (w_rem_nx),
    .quo_next (w_quo_nx)
  );

  assign w_last = (r_cnt == '0);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nx = ST_PREP;
      end
      ST_PREP: begin
        busy       = 1'b1;
        w_state_nx = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Flush wins over everything except reset, including a same-cycle start.
    if (cancel) w_state_nx = ST_IDLE;
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dsr   <= '0;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (!cancel) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sgn <= is_signed;
            r_quo <= dividend;
            r_dsr <= divisor;
          end
        end
        ST_PREP: begin
          // Work in magnitudes; signs are reapplied on the way out.
          // Remainder takes the dividend's sign, quotient the XOR of both.
          r_q_neg <= r_sgn & (r_quo[DATA_BUS-1] ^ r_dsr[DATA_BUS-1]);
          r_r_neg <= r_sgn & r_quo[DATA_BUS-1];
          if (r_sgn) begin
            r_quo <= abs32(r_quo);
            r_dsr <= abs32(r_dsr);
          end
          r_rem <= '0;
          r_cnt <= c_CNT_LOAD;
        end
        ST_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          // Results land on the edge that enters DONE, straight from the
          // final iteration, so they are valid while done is high.
          if (w_last) begin
            r_hi <= r_r_neg ? neg32(w_rem_nx[DATA_BUS-1:0]) : w_rem_nx[DATA_BUS-1:0];
            r_lo <= r_q_neg ? neg32(w_quo_nx) : w_quo_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit. Inputs change on
//                the falling edge, outputs are sampled on the falling edge.
//                Loop index c counts cycles after the start edge k, so the
//                sample taken at index c reflects cycle k+c.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_vec;
  int n_err;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge (cycle k); returns at the falling edge of k+1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat = cycles after the start edge, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r);
    int lat;
    issue(s, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd34);
    chk({tag, "_lo"}, lo_out, exp_q);
    chk({tag, "_hi"}, hi_out, exp_r);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    cancel    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 100 / 7 with cycle-exact busy/done profile
    issue(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 35; c++) begin
      chk($sformatf("u100_7_busy_c%0d", c), {31'd0, busy}, (c <= 34) ? 32'd1 : 32'd0);
      chk($sformatf("u100_7_done_c%0d", c), {31'd0, done}, (c == 34) ? 32'd1 : 32'd0);
      if (c == 34) begin
        chk("u100_7_lo", lo_out, 32'd14);
        chk("u100_7_hi", hi_out, 32'd2);
      end
      @(negedge clk);
    end
    chk("u100_7_hold_lo", lo_out, 32'd14);
    chk("u100_7_hold_hi", hi_out, 32'd2);

    // Signed cases and divide by zero
    run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    run_op("s_7_m2",   1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    run_op("u_big",    1'b0, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'h0000_0001);
    run_op("u_div0",   1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678);
    run_op("s_div0",   1'b1, 32'hFFFF_FFF0, 32'd0,        32'h0000_0001, 32'hFFFF_FFF0);

    // Cancel in cycle k+10, restart in cycle k+11, completes at k+45
    issue(1'b0, 32'd1000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("cxl_busy_c%0d", c), {31'd0, busy}, 32'd1);
      chk($sformatf("cxl_done_c%0d", c), {31'd0, done}, 32'd0);
      if (c == 10) cancel = 1'b1;
      @(negedge clk);
    end
    cancel = 1'b0;
    chk("cxl_busy_k11", {31'd0, busy}, 32'd0);
    chk("cxl_done_k11", {31'd0, done}, 32'd0);
    chk("cxl_lo_kept", lo_out, 32'h0000_0001);
    chk("cxl_hi_kept", hi_out, 32'hFFFF_FFF0);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd6;
    @(negedge clk);
    start = 1'b0;
    for (int c = 12; c <= 45; c++) begin
      chk($sformatf("cxl_re_done_c%0d", c), {31'd0, done}, (c == 45) ? 32'd1 : 32'd0);
      if (c == 45) begin
        chk("cxl_re_lo", lo_out, 32'd8);
        chk("cxl_re_hi", hi_out, 32'd2);
      end
      @(negedge clk);
    end

    // Start while busy is ignored
    issue(1'b0, 32'd200, 32'd9);
    for (int c = 1; c <= 34; c++) begin
      if (c == 5) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'hFFFF_FF00;
        divisor   = 32'd5;
      end
      if (c == 6) start = 1'b0;
      chk($sformatf("ign_done_c%0d", c), {31'd0, done}, (c == 34) ? 32'd1 : 32'd0);
      if (c == 34) begin
        chk("ign_lo", lo_out, 32'd22);
        chk("ign_hi", hi_out, 32'd2);
      end
      @(negedge clk);
    end
    chk("ign_busy_after", {31'd0, busy}, 32'd0);

    // Reset in cycle k+20
    issue(1'b0, 32'd500, 32'd4);
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_hi", hi_out, 32'd0);
    chk("mrst_lo", lo_out, 32'd0);
    for (int c = 22; c <= 40; c++) begin
      @(negedge clk);
      chk($sformatf("mrst_nodone_c%0d", c), {31'd0, done}, 32'd0);
    end

    // Recovery after reset
    run_op("post_rst", 1'b0, 32'd500, 32'd4, 32'd125, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_div_unit
`default_nettype wire
